// File: rtl/w5300_bus_arbiter_if.sv
// W5300 register-bus bundle between the arbiter (master) and the bus-interface FSM (slave).
interface w5300_bus_arbiter_if;
    logic [10:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        op_state;

    modport master (
        output addr,
        output wr_data,
        input  rd_data,
        input  op_state
    );

    modport slave (
        input  addr,
        input  wr_data,
        output rd_data,
        output op_state
    );
endinterface

// File: rtl/w5300_bus_arbiter.sv
// Round-robin owner arbiter for the shared W5300 register bus.
// An owner keeps the bus for a whole multi-access sequence until it drops
// its request or the watchdog revokes it. Re-arbitration only happens once
// the bus interface reports idle, so an access is never cut in half.
module w5300_bus_arbiter #(
    parameter int          NUM_REQ        = 4,
    // bit 10 is the rd/wr flag (1 = read), bits 9:0 the register offset
    parameter logic [10:0] IDLE_ADDR      = 11'h7FE,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*11-1:0]   req_addr_i,
    input  logic [NUM_REQ*16-1:0]   req_wr_data_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [NUM_REQ-1:0]      req_op_state_o,
    output logic [15:0]             req_rd_data_o,
    output logic                    timeout_err_o,
    w5300_bus_arbiter_if.master     bus
);

    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam logic [TW-1:0] TLIM = (TIMEOUT_CYCLES == 0) ? {TW{1'b0}} : TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [IW-1:0]        pick_s;
    logic                 found_s;

    assign grant_o       = grant_q;
    assign timeout_err_o = timeout_err_q;
    assign req_rd_data_o = bus.rd_data;

    // Round-robin scan: first set request at or above rr_ptr, wrapping.
    always_comb begin
        int            sum_v;
        logic [IW-1:0] cand_v;
        pick_s  = {IW{1'b0}};
        found_s = 1'b0;
        sum_v   = 0;
        cand_v  = {IW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_v = int'(rr_ptr_q) + i;
            if (sum_v >= NUM_REQ) begin
                sum_v = sum_v - NUM_REQ;
            end else begin
                sum_v = sum_v;
            end
            cand_v = IW'(sum_v);
            if (!found_s && req_i[cand_v]) begin
                found_s = 1'b1;
                pick_s  = cand_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic and bus mux; the mux only ever reads the owner's slice.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        grant_d       = grant_q;
        timeout_err_d = 1'b0;
        bus.addr      = IDLE_ADDR;
        bus.wr_data   = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if ((|req_i) && bus.op_state && found_s) begin
                    owner_d  = pick_s;
                    grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                    rr_ptr_d = (pick_s == LAST) ? {IW{1'b0}} : pick_s + {{(IW-1){1'b0}}, 1'b1};
                    timer_d  = {TW{1'b0}};
                    state_d  = ST_OWNED;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_OWNED: begin
                bus.addr    = req_addr_i[int'(owner_q)*11 +: 11];
                bus.wr_data = req_wr_data_i[int'(owner_q)*16 +: 16];
                if (timer_q == {TW{1'b1}}) begin
                    timer_d = timer_q;
                end else begin
                    timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                end
                // a voluntary release wins over an expiring watchdog
                if (!req_i[owner_q]) begin
                    grant_d = {NUM_REQ{1'b0}};
                    state_d = ST_RELEASE;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TLIM)) begin
                    grant_d       = {NUM_REQ{1'b0}};
                    timeout_err_d = 1'b1;
                    state_d       = ST_RELEASE;
                end else begin
                    state_d = ST_OWNED;
                end
            end
            ST_RELEASE: begin
                // let the in-flight access finish before anyone else gets the bus
                if (bus.op_state) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                grant_d = {NUM_REQ{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // Route op_state to the current owner only.
    always_comb begin
        req_op_state_o = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_q == ST_OWNED) && (owner_q == IW'(i))) begin
                req_op_state_o[i] = bus.op_state;
            end else begin
                req_op_state_o[i] = 1'b0;
            end
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= {IW{1'b0}};
            rr_ptr_q      <= {IW{1'b0}};
            timer_q       <= {TW{1'b0}};
            grant_q       <= {NUM_REQ{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            grant_q       <= grant_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed bench for w5300_bus_arbiter (4 requesters, 16-cycle watchdog).
module tb_w5300_bus_arbiter;

    localparam logic [10:0] IDLE = 11'h7FE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [43:0] req_addr;
    logic [63:0] req_wr_data;
    logic [3:0]  grant;
    logic [3:0]  req_op_state;
    logic [15:0] req_rd_data;
    logic        timeout_err;
    int          checks = 0;
    int          errors = 0;

    w5300_bus_arbiter_if bus_if ();

    w5300_bus_arbiter #(
        .NUM_REQ        (4),
        .IDLE_ADDR      (IDLE),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .req_addr_i     (req_addr),
        .req_wr_data_i  (req_wr_data),
        .grant_o        (grant),
        .req_op_state_o (req_op_state),
        .req_rd_data_o  (req_rd_data),
        .timeout_err_o  (timeout_err),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_slices();
        req_addr    = {11'h133, 11'h122, 11'h111, 11'h100};
        req_wr_data = {16'hA303, 16'hA202, 16'hA101, 16'hA000};
    endtask

    task automatic do_reset();
        req = 4'b0000;
        bus_if.op_state = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.rd_data = 16'h1234;
        #3;
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_regs grant=%b tmo=%b want 0000/0", grant, timeout_err);
        end
        checks++;
        if (bus_if.addr !== IDLE || bus_if.wr_data !== 16'h0000 || req_op_state !== 4'b0000) begin
            errors++; $display("FAIL reset_bus addr=%h wd=%h ops=%b want %h/0000/0000", bus_if.addr, bus_if.wr_data, req_op_state, IDLE);
        end
        checks++;
        if (req_rd_data !== 16'h1234) begin
            errors++; $display("FAIL rd_broadcast got=%h want 1234", req_rd_data);
        end
        bus_if.rd_data = 16'hBEEF;
        #1;
        checks++;
        if (req_rd_data !== 16'hBEEF) begin
            errors++; $display("FAIL rd_follow got=%h want beef", req_rd_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL single_early grant=%b want 0000", grant);
        end
        tick();
        checks++;
        if (grant !== 4'b0100 || bus_if.addr !== 11'h122 || bus_if.wr_data !== 16'hA202) begin
            errors++; $display("FAIL single_grant grant=%b addr=%h wd=%h want 0100/122/a202", grant, bus_if.addr, bus_if.wr_data);
        end
        checks++;
        if (req_op_state !== 4'b0100) begin
            errors++; $display("FAIL single_ops_hi got=%b want 0100", req_op_state);
        end
        bus_if.op_state = 1'b0;
        req_addr[11 +: 11] = 11'bx;
        req_wr_data[16 +: 16] = 16'bx;
        #1;
        checks++;
        if (req_op_state !== 4'b0000 || bus_if.addr !== 11'h122 || bus_if.wr_data !== 16'hA202) begin
            errors++; $display("FAIL single_ops_lo ops=%b addr=%h wd=%h want 0000/122/a202", req_op_state, bus_if.addr, bus_if.wr_data);
        end
        load_slices();
        bus_if.op_state = 1'b1;
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || bus_if.addr !== IDLE || req_op_state !== 4'b0000) begin
            errors++; $display("FAIL single_release grant=%b addr=%h ops=%b want 0000/%h/0000", grant, bus_if.addr, req_op_state, IDLE);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int held;
        do_reset();
        req = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            held = 0;
            for (int c = 0; c < 5; c++) begin
                if (grant === (4'b0001 << order[n])) held++;
                if (c == 4) req[order[n]] = 1'b0;
                tick();
            end
            checks++;
            if (held != 5) begin
                errors++; $display("FAIL rr_owner%0d held=%0d cycles want 5 (owner %0d)", n, held, order[n]);
            end
            checks++;
            if (grant !== 4'b0000) begin
                errors++; $display("FAIL rr_release%0d grant=%b want 0000", n, grant);
            end
            req[order[n]] = 1'b1;
            tick();
            tick();
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_bus_busy();
        int bad;
        do_reset();
        bus_if.op_state = 1'b0;
        req = 4'b0010;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (grant !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL busy_nogrant grant_cycles=%0d want 0", bad);
        end
        bus_if.op_state = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0010 || bus_if.addr !== 11'h111) begin
            errors++; $display("FAIL busy_grant grant=%b addr=%h want 0010/111", grant, bus_if.addr);
        end
    endtask

    task automatic test_watchdog();
        int held;
        int early;
        do_reset();
        req = 4'b1001;
        held = 0;
        early = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (grant === 4'b0001) held++;
            if (timeout_err !== 1'b0) early++;
        end
        checks++;
        if (held != 16 || early != 0) begin
            errors++; $display("FAIL wd_hold held=%0d early_pulses=%0d want 16/0", held, early);
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL wd_revoke grant=%b tmo=%b want 0000/1", grant, timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || grant !== 4'b0000) begin
            errors++; $display("FAIL wd_pulse_len tmo=%b grant=%b want 0/0000", timeout_err, grant);
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || bus_if.addr !== 11'h133) begin
            errors++; $display("FAIL wd_next grant=%b addr=%h want 1000/133", grant, bus_if.addr);
        end
    endtask

    task automatic test_collision();
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 0; c < 15; c++) tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL coll_pre grant=%b want 0001", grant);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL coll_noerr grant=%b tmo=%b want 0000/0", grant, timeout_err);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL coll_release grant=%b tmo=%b want 0000/0", grant, timeout_err);
        end
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL coll_regrant grant=%b want 0001", grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            errors++; $display("FAIL rmid_pre grant=%b want 0010", grant);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || bus_if.addr !== IDLE || bus_if.wr_data !== 16'h0000 || req_op_state !== 4'b0000) begin
            errors++; $display("FAIL rmid_async grant=%b addr=%h wd=%h ops=%b want 0000/%h/0000/0000", grant, bus_if.addr, bus_if.wr_data, req_op_state, IDLE);
        end
        req = 4'b1010;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0010 || bus_if.addr !== 11'h111) begin
            errors++; $display("FAIL rmid_after grant=%b addr=%h want 0010/111", grant, bus_if.addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        load_slices();
        bus_if.op_state = 1'b1;
        bus_if.rd_data  = 16'h0000;
        test_reset();
        test_single();
        test_round_robin();
        test_bus_busy();
        test_watchdog();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w5300_bus_arbiter.md
# w5300_bus_arbiter

Round-robin arbiter that shares the single W5300 register-bus port (`addr`, `wr_data`, `rd_data`, `op_state`) between up to `NUM_REQ` socket engines: receivers, transmitters and the configurator. A requester holds ownership for a whole multi-access sequence, for example size read → FIFO burst → RECV command. Ownership is revoked only on release or watchdog timeout. The block sits between the per-socket engines and the W5300 bus-interface FSM.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `IDLE_ADDR`, default `{RD, 10'h3FE}`: `addr` value driven when no owner. `RD` is the W5300 package constant.
- `TIMEOUT_CYCLES`, default 65535: maximum cycles of one ownership. 0 disables the watchdog.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: level request per requester, held for the whole sequence.
- `req_addr` in NUM_REQ*11: flattened `{rd/wr, reg}` per requester. Requester i uses bits [i*11 +: 11].
- `req_wr_data` in NUM_REQ*16: flattened write data per requester.
- `grant` out NUM_REQ: one-hot owner, registered.
- `req_op_state` out NUM_REQ: bus `op_state` routed to the owner only.
- `req_rd_data` out 16: `rd_data`, broadcast to all requesters.
- `timeout_err` out 1: one-cycle pulse when the watchdog revokes ownership.
- `addr` out 11: to the bus interface.
- `wr_data` out 16: to the bus interface.
- `rd_data` in 16: from the bus interface.
- `op_state` in 1: bus interface idle/complete.

## Operation
- State machine `state` has three states: Idle, Owned, Release. Registers: `owner` index, `rr_ptr`, `timer`.
- Idle:
  - `addr = IDLE_ADDR` and `wr_data = 0`.
  - If `|req && op_state`: pick the first set `req[k]` scanning from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - On that pick: `owner <= k`, `grant <= 1<<k`, `rr_ptr <= (k+1) % NUM_REQ`, `timer <= 0`, go to Owned.
  - Otherwise stay in Idle.
- Owned:
  - `addr`/`wr_data` = owner's slices (combinational mux).
  - `req_op_state[owner] = op_state`; all other bits are 0.
  - `timer` increments and saturates.
  - If `!req[owner]`: `grant <= 0`, go to Release.
  - Else if `TIMEOUT_CYCLES != 0 && timer == TIMEOUT_CYCLES-1`: `grant <= 0`, pulse `timeout_err`, go to Release.
  - Release has priority over timeout when both occur in the same cycle; no error pulse is given in that case.
- Release:
  - `addr = IDLE_ADDR` and all `req_op_state` bits are 0.
  - Go to Idle when `op_state == 1`. An in-flight bus access completes before re-arbitration.
- Arbitration happens only in Idle with `op_state == 1`, so the bus never switches owner mid-access.
- Requests from non-owners are ignored until the next Idle. No queueing is needed because `req` is level-held.
- A requester that drops `req` and raises it again in the next cycle waits a full round; `rr_ptr` has already moved past it.
- Width of `timer` is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit.
- X on non-owner slices must never reach `addr`/`wr_data`.

## Timing
- Reset values:
  - `state` = Idle, `grant` = 0, `owner` = 0, `rr_ptr` = 0, `timer` = 0, `timeout_err` = 0.
  - `addr = IDLE_ADDR`, `wr_data = 0`, `req_op_state = 0`.
  - `req_rd_data` follows `rd_data` at all times.
- Grant latency: `req[k]` rises in cycle t while in Idle with `op_state == 1` → `grant[k]` = 1 and the bus carries k's address in cycle t+1.
- Release latency: `req[k]` falls in cycle t → `grant` = 0 and `addr = IDLE_ADDR` in t+1. The earliest next grant is t+3 (Release, then Idle evaluation).
- Watchdog: ownership lasts exactly `TIMEOUT_CYCLES` cycles in Owned. `timeout_err` is high for the single cycle in which `grant` clears.
- Reset asserted mid-ownership: outputs return to reset values immediately (asynchronous). After deassertion the first grant goes to the lowest set `req` index.

## Test plan
- Single requester: `req[2]`=1 with `op_state`=1 → `grant`=4'b0100 next cycle; `addr` = `req_addr[2]` slice; only `req_op_state[2]` follows `op_state`. Drop `req[2]` → `addr`=`IDLE_ADDR` next cycle.
- Round-robin: `req`=4'b1111 held, each owner releases after 5 cycles → grant order 0,1,2,3,0; each owner observes 5 cycles of grant.
- Bus busy: `req[1]`=1 while `op_state`=0 for 10 cycles → no grant. `op_state` rises → `grant[1]` the following cycle.
- Watchdog: `TIMEOUT_CYCLES`=16, `req[0]` held forever with `req[3]` also set → `grant[0]` for exactly 16 cycles, one `timeout_err` pulse, then `grant[3]`.
- Release/timeout collision: `req[0]` drops in the same cycle the timer expires → `timeout_err` stays 0 and the FSM enters Release.
- Reset mid-ownership: `rst_n` pulled low while `grant`=4'b0010 → `grant`=0 and `addr`=`IDLE_ADDR` without waiting for a clock edge. After reset with `req`=4'b1010 → `grant`=4'b0010.
